// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: issue/result bundle between the EX stage and the multiply/divide unit
interface mult_div_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   modport master (output start, op, src_a, src_b, input busy, hi, lo);
   modport slave (input start, op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency multiply/divide unit holding its result until the busy window ends
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input logic clk,
   input logic reset,
   mult_div_unit_if.slave bus
);
   localparam int unsigned MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic busy, busy_n;
   logic [31:0] hi, hi_n, lo, lo_n, pend_hi, pend_hi_n, pend_lo, pend_lo_n;
   logic [31:0] a, b, abs_a, abs_b, q_mag, r_mag, sq, sr;
   logic [63:0] prod_s, prod_u, res;
   assign a = bus.src_a;
   assign b = bus.src_b;
   assign bus.busy = busy;
   assign bus.hi = hi;
   assign bus.lo = lo;
   // Result of the issued op; signed divide works on magnitudes so INT_MIN/-1 wraps to INT_MIN
   always_comb begin
      abs_a = a[31] ? -a : a;
      abs_b = b[31] ? -b : b;
      q_mag = abs_a / abs_b;
      r_mag = abs_a % abs_b;
      sq = (a[31] ^ b[31]) ? -q_mag : q_mag;
      sr = a[31] ? -r_mag : r_mag;
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u = {32'b0, a} * {32'b0, b};
      res = bus.op == 3'd0 ? prod_s :
            bus.op == 3'd1 ? prod_u :
            b == '0        ? {hi, lo} :
            bus.op == 3'd2 ? {sr, sq} : {a % b, a / b};
   end
   // Next-state: accept ops only in IDLE, count down in RUN and commit the pending result on the last cycle
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      busy_n = busy;
      hi_n = hi;
      lo_n = lo;
      pend_hi_n = pend_hi;
      pend_lo_n = pend_lo;
      if (state == IDLE) begin
         if (bus.start && !bus.op[2]) begin
            state_n = RUN;
            busy_n = 1'b1;
            cnt_n = bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            {pend_hi_n, pend_lo_n} = res;
         end else if (bus.start && bus.op == 3'd4) begin
            hi_n = a;
         end else if (bus.start && bus.op == 3'd5) begin
            lo_n = a;
         end
      end else begin
         cnt_n = cnt - CW'(1);
         if (cnt == CW'(1)) begin
            state_n = IDLE;
            busy_n = 1'b0;
            hi_n = pend_hi;
            lo_n = pend_lo;
         end
      end
   end
   // State register with synchronous active-low reset that also drops any pending result
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         busy <= 1'b0;
         hi <= '0;
         lo <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         busy <= busy_n;
         hi <= hi_n;
         lo <= lo_n;
         pend_hi <= pend_hi_n;
         pend_lo <= pend_lo_n;
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table, corner-case and randomized checks of mult_div_unit against a reference model
module tb_mult_div_unit;
   logic clk = 1'b0;
   logic reset;
   int tests = 0;
   int fails = 0;
   logic [31:0] m_hi, m_lo;
   mult_div_unit_if bus ();
   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
      int          lat;
   } vec_t;
   vec_t tv[10];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] h, input logic [31:0] l);
      logic [63:0] ua, ub;
      int sa, sb;
      ua = {32'b0, a};
      ub = {32'b0, b};
      sa = a;
      sb = b;
      case (op)
         3'd0: return longint'(sa) * longint'(sb);
         3'd1: return ua * ub;
         3'd2: begin
            if (b == 0) return {h, l};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         3'd3: return b == 0 ? {h, l} : {a % b, a / b};
         3'd4: return {a, l};
         3'd5: return {h, a};
         default: return {h, l};
      endcase
   endfunction
   function automatic int latency(input logic [2:0] op);
      return op < 2 ? 5 : op < 4 ? 10 : 0;
   endfunction
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int lat);
      int n;
      bit hold_ok;
      bus.start = 1'b1;
      bus.op = op;
      bus.src_a = a;
      bus.src_b = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op = 3'd7;
      n = 0;
      hold_ok = 1'b1;
      while (bus.busy === 1'b1 && n < 100) begin
         if (bus.hi !== m_hi || bus.lo !== m_lo) hold_ok = 1'b0;
         n++;
         @(posedge clk);
         #1;
      end
      chk({name, " busy_cycles"}, 64'(n), 64'(lat));
      if (lat > 0) chk({name, " hold_during_run"}, 64'(hold_ok), 64'd1);
      chk({name, " hi"}, 64'(bus.hi), 64'(eh));
      chk({name, " lo"}, 64'(bus.lo), 64'(el));
      m_hi = eh;
      m_lo = el;
   endtask
   initial begin
      logic [2:0] rop;
      logic [31:0] ra, rb;
      logic [63:0] e;
      int n;
      tv[0] = '{3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      tv[1] = '{3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5};
      tv[2] = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      tv[3] = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10};
      tv[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10};
      tv[5] = '{3'd4, 32'h11, 32'h0, 32'h11, 32'h80000000, 0};
      tv[6] = '{3'd5, 32'h22, 32'h0, 32'h11, 32'h22, 0};
      tv[7] = '{3'd3, 32'd5, 32'd0, 32'h11, 32'h22, 10};
      tv[8] = '{3'd5, 32'hABCD, 32'h0, 32'h11, 32'hABCD, 0};
      tv[9] = '{3'd6, 32'hDEAD, 32'hBEEF, 32'h11, 32'hABCD, 0};
      reset = 1'b0;
      bus.start = 1'b0;
      bus.op = 3'd7;
      bus.src_a = '0;
      bus.src_b = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset hi", 64'(bus.hi), 64'd0);
      chk("reset lo", 64'(bus.lo), 64'd0);
      m_hi = '0;
      m_lo = '0;
      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].eh, tv[i].el, tv[i].lat);
      bus.start = 1'b1;
      bus.op = 3'd0;
      bus.src_a = 32'd3;
      bus.src_b = 32'd4;
      @(posedge clk);
      #1;
      n = 0;
      for (int i = 0; i < 2; i++) begin
         if (bus.busy === 1'b1) n++;
         bus.start = 1'b1;
         bus.op = i == 0 ? 3'd5 : 3'd0;
         bus.src_a = i == 0 ? 32'h5555 : 32'd100;
         bus.src_b = 32'd100;
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      bus.op = 3'd7;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk("start_while_busy busy_cycles", 64'(n), 64'd5);
      chk("start_while_busy hi", 64'(bus.hi), 64'd0);
      chk("start_while_busy lo", 64'(bus.lo), 64'd12);
      m_hi = 32'd0;
      m_lo = 32'd12;
      run_op("pre_reset_fill", 3'd4, 32'h77, 32'h0, 32'h77, 32'd12, 0);
      bus.start = 1'b1;
      bus.op = 3'd0;
      bus.src_a = 32'd3;
      bus.src_b = 32'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op = 3'd7;
      repeat (2) @(posedge clk);
      #1;
      chk("midop busy_before_reset", 64'(bus.busy), 64'd1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk("midop_reset busy", 64'(bus.busy), 64'd0);
      chk("midop_reset hi", 64'(bus.hi), 64'd0);
      chk("midop_reset lo", 64'(bus.lo), 64'd0);
      n = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.lo !== 32'd0 || bus.busy !== 1'b0) n++;
      end
      chk("no_late_write", 64'(n), 64'd0);
      m_hi = '0;
      m_lo = '0;
      run_op("b2b_first", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12, 5);
      run_op("b2b_second", 3'd0, 32'd5, 32'd6, 32'd0, 32'd30, 5);
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 6));
         ra = $urandom;
         rb = (i % 7 == 3) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if (i % 5 == 1) ra = -32'($urandom_range(0, 1000));
         e = model(rop, ra, rb, m_hi, m_lo);
         run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, e[63:32], e[31:0], latency(rop));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
